req_ack_responder: RTL and testbench

// Responder side of the single-wire req/ack handshake used by the test benches.
// - Detects each rising edge of req.
// - Answers each rising edge with an ack pulse of ACK_LEN cycles, issued DELAY cycles later.
// - Queues requests that arrive while busy, up to PEND_DEPTH of them.
// - Flags requests that overflow the queue, and counts requests served.

---
 rtl/req_ack_responder.sv | 123 ++++++++++++
 tb/tb_req_ack_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/req_ack_responder.sv
// Responder for a single-wire req/ack handshake: every rising edge of req is answered by an
// ack pulse of ACK_LEN cycles, DELAY cycles later, with a bounded queue for requests seen while busy.
module req_ack_responder #(
  parameter int unsigned DELAY      = 2,
  parameter int unsigned ACK_LEN    = 1,
  parameter int unsigned PEND_DEPTH = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_i,
  output logic                              ack_o,
  output logic                              busy_o,
  output logic [$clog2(PEND_DEPTH+1)-1:0]   pend_o,
  output logic                              drop_o,
  output logic [CNT_W-1:0]                  served_o
);

  localparam int unsigned PW = $clog2(PEND_DEPTH + 1);
  localparam logic [3:0] DelayLd = 4'(DELAY - 1);
  localparam logic [3:0] AckLd   = 4'(ACK_LEN - 1);
  localparam logic [PW-1:0] PendMax = PW'(PEND_DEPTH);

  typedef enum logic [1:0] {StIdle, StDelay, StAck} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             req_q;
  logic             ack_q;
  logic             drop_q;
  logic [PW-1:0]    pend_q;
  logic [CNT_W-1:0] served_q;

  logic          rise;
  logic          ack_done;
  logic          take_pend;
  logic          consume;
  logic          start;
  logic          queue_rise;
  logic          drop_d;
  logic [PW-1:0] pend_left;
  logic [PW-1:0] pend_d;

  // Service slot frees in IDLE or on the last ACK cycle; queued work has priority over a new rise.
  always_comb begin
    rise      = req_i & ~req_q;
    ack_done  = (state_q == StAck) && (cnt_q == 4'd0);
    take_pend = 1'b0;
    consume   = 1'b0;
    if ((state_q == StIdle) || ack_done) begin
      if (pend_q != '0) begin
        take_pend = 1'b1;
      end else begin
        consume = rise;
      end
    end
    start      = take_pend | consume;
    pend_left  = pend_q - PW'(take_pend);
    queue_rise = rise & ~consume;
    drop_d     = queue_rise && (pend_left == PendMax);
    pend_d     = pend_left + PW'(queue_rise & ~drop_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      req_q    <= 1'b0;
      ack_q    <= 1'b0;
      drop_q   <= 1'b0;
      pend_q   <= '0;
      served_q <= '0;
    end else begin
      req_q  <= req_i;
      drop_q <= drop_d;
      pend_q <= pend_d;
      if (ack_done) begin
        served_q <= served_q + CNT_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StDelay;
            cnt_q   <= DelayLd;
          end
        end
        StDelay: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StAck;
            ack_q   <= 1'b1;
            cnt_q   <= AckLd;
          end
        end
        StAck: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ack_q <= 1'b0;
            if (start) begin
              state_q <= StDelay;
              cnt_q   <= DelayLd;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o    = ack_q;
  assign busy_o   = (state_q != StIdle);
  assign pend_o   = pend_q;
  assign drop_o   = drop_q;
  assign served_o = served_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: a timeline model schedules each request's ack window and drops;
// a negedge monitor pops and compares those against what the DUT presents.
module tb_req_ack_responder;

  localparam int unsigned DELAY      = 2;
  localparam int unsigned ACK_LEN    = 1;
  localparam int unsigned PEND_DEPTH = 3;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned PW         = $clog2(PEND_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic             ack;
  logic             busy;
  logic [PW-1:0]    pend;
  logic             drop;
  logic [CNT_W-1:0] served;

  int checks = 0;
  int errors = 0;

  req_ack_responder #(
    .DELAY      (DELAY),
    .ACK_LEN    (ACK_LEN),
    .PEND_DEPTH (PEND_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .ack_o    (ack),
    .busy_o   (busy),
    .pend_o   (pend),
    .drop_o   (drop),
    .served_o (served)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference timeline: request i occupies [start, start+DELAY+ACK_LEN), ack over the last ACK_LEN.
  int unsigned ecnt;
  int unsigned free_at;
  int unsigned n_acc;
  int unsigned n_drop_exp;
  bit          m_req;
  int unsigned starts[$];
  int unsigned exp_ack_q[$];
  int unsigned exp_srv_q[$];
  int unsigned exp_drop_q[$];
  int unsigned exp_pend;
  bit          exp_busy;
  bit          exp_ack;

  always @(posedge clk or posedge rst) begin : model
    int unsigned n, s, waiting;
    bit rise;
    if (rst) begin
      ecnt = 0; free_at = 0; n_acc = 0; n_drop_exp = 0; m_req = 0;
      starts.delete(); exp_ack_q.delete(); exp_srv_q.delete(); exp_drop_q.delete();
      exp_pend = 0; exp_busy = 0; exp_ack = 0;
    end else begin
      ecnt = ecnt + 1;
      n = ecnt;
      rise = req && !m_req;
      m_req = req;
      while (starts.size() > 0 && starts[0] + DELAY + ACK_LEN <= n) void'(starts.pop_front());
      if (rise) begin
        s = (free_at > n) ? free_at : n;
        waiting = 0;
        foreach (starts[i]) if (starts[i] > n) waiting++;
        if (s > n && waiting >= PEND_DEPTH) begin
          exp_drop_q.push_back(n);
          n_drop_exp++;
        end else begin
          starts.push_back(s);
          exp_ack_q.push_back(s + DELAY);
          exp_srv_q.push_back(n_acc % (1 << CNT_W));
          n_acc++;
          free_at = s + DELAY + ACK_LEN;
        end
      end
      exp_pend = 0; exp_busy = 0; exp_ack = 0;
      foreach (starts[i]) begin
        if (starts[i] > n) exp_pend++;
        if (starts[i] <= n && n < starts[i] + DELAY + ACK_LEN) exp_busy = 1;
        if (starts[i] + DELAY <= n && n < starts[i] + DELAY + ACK_LEN) exp_ack = 1;
      end
    end
  end

  bit prev_ack;
  int drops_seen;

  always @(negedge clk) begin : monitor
    if (!rst) begin
      check("pend", pend, exp_pend);
      check("busy", busy, exp_busy);
      check("ack_level", ack, exp_ack);
      if (ack && !prev_ack) begin
        if (exp_ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected: ack rose after edge %0d, expected no pulse", ecnt);
        end else begin
          check("ack_rise_edge", ecnt, exp_ack_q.pop_front());
          check("served_at_ack", served, exp_srv_q.pop_front());
        end
      end
      if (drop) begin
        drops_seen++;
        if (exp_drop_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL drop_unexpected: drop after edge %0d, expected none", ecnt);
        end else begin
          check("drop_edge", ecnt, exp_drop_q.pop_front());
        end
      end
      prev_ack = ack;
    end else begin
      prev_ack = 0;
      drops_seen = 0;
    end
  end

  task automatic pulse_rises(input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk); req = 1'b1;
      @(negedge clk); req = 1'b0;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit hit;
    rst = 1'b1;
    req = 1'b0;
    // Reset with req toggling: every output held at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_pend", pend, 0);
      check("rst_drop", drop, 0);
      check("rst_served", served, 0);
      req = ~req;
    end
    @(negedge clk);
    req = 1'b0;
    #1 rst = 1'b0;

    // Single one-cycle request.
    repeat (9) @(negedge clk);
    req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (8) @(negedge clk);
    check("served_single", served, 1);
    check("idle_after_single", busy, 0);

    // Four rises two cycles apart.
    pulse_rises(4);
    repeat (20) @(negedge clk);
    check("served_four", served, 5);
    check("no_drop_four", drops_seen, 0);

    // Held-high req is one request; re-raise is another.
    @(negedge clk); req = 1'b1;
    repeat (20) @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    check("served_held", served, 6);
    req = 1'b1;
    repeat (10) @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    check("served_reraise", served, 7);

    // Sustained burst overflows the queue.
    pulse_rises(40);
    repeat (60) @(negedge clk);
    check("burst_drop_count", drops_seen, n_drop_exp);
    check("burst_dropped_any", (drops_seen > 0), 1);

    // Random req activity.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req = ($urandom_range(0, 2) != 0) ? ~req : req;
    end
    req = 1'b0;
    repeat (60) @(negedge clk);
    check("ack_queue_drained", exp_ack_q.size(), 0);
    check("drop_queue_drained", exp_drop_q.size(), 0);
    check("served_final", served, n_acc % (1 << CNT_W));
    check("drop_total", drops_seen, n_drop_exp);

    // Reset mid-pulse with work queued: ack drops before the next edge, queue cleared.
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (ack && pend >= 2) hit = 1;
      else req = ~req;
    end
    check("found_ack_with_pend", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ack", ack, 0);
    check("async_rst_pend", pend, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_served", served, 0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    check("no_ack_after_rst", exp_ack_q.size(), 0);
    check("served_after_rst", served, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
